// File: rtl/mem_port_arbiter.sv
// Two-port arbiter onto one memory bus: port 0 single accesses, port 1 incrementing bursts.
// Latency: grant and strobes one edge after a request seen in IDLE; ack/rdata one edge after each beat.
// Backpressure: none; a losing or late requester waits in place until the arbiter returns to IDLE.
//
// Ports:
//   clk, reset (async, active-low)
//   req0/we0/addr0/wdata0          port-0 single access request
//   req1/we1/addr1/wdata1/len1     port-1 burst request (len1 = beats - 1)
//   gnt0/gnt1, ack0/ack1, last1    grant flags and per-beat completion pulses
//   rdata0/rdata1                  registered read data, valid with the matching ack
//   Mem_addr/Mem_wdata/MemRead/MemWrite, Mem_data   shared memory bus
//   busy                           arbiter is not IDLE
module mem_port_arbiter #(
    parameter int BURST_W   = 4,
    parameter int ADDR_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic               we0,
    input  logic [31:0]        addr0,
    input  logic [31:0]        wdata0,
    input  logic               req1,
    input  logic               we1,
    input  logic [31:0]        addr1,
    input  logic [31:0]        wdata1,
    input  logic [BURST_W-1:0] len1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               ack0,
    output logic               ack1,
    output logic               last1,
    output logic [31:0]        rdata0,
    output logic [31:0]        rdata1,
    output logic [31:0]        Mem_addr,
    output logic [31:0]        Mem_wdata,
    output logic               MemRead,
    output logic               MemWrite,
    input  logic [31:0]        Mem_data,
    output logic               busy
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    // Set when port 0 was granted last, so port 1 wins the next tie.
    logic               prio1_q;
    logic [BURST_W-1:0] beat_q;
    logic [BURST_W-1:0] len_q;
    logic               grant0, grant1, burst_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant0    = 1'b0;
        grant1    = 1'b0;
        burst_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || !prio1_q)) begin
                    grant0  = 1'b1;
                    state_d = ACC0;
                end else if (req1) begin
                    grant1  = 1'b1;
                    state_d = ACC1;
                end
            end
            ACC0: state_d = IDLE;
            ACC1: begin
                if (beat_q == len_q) begin
                    burst_end = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio1_q   <= 1'b0;
            beat_q    <= '0;
            len_q     <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            last1     <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            Mem_addr  <= '0;
            Mem_wdata <= '0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            last1 <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant0) begin
                        prio1_q   <= 1'b1;
                        gnt0      <= 1'b1;
                        Mem_addr  <= addr0;
                        Mem_wdata <= wdata0;
                        MemRead   <= !we0;
                        MemWrite  <= we0;
                    end else if (grant1) begin
                        prio1_q   <= 1'b0;
                        gnt1      <= 1'b1;
                        beat_q    <= '0;
                        len_q     <= len1;
                        Mem_addr  <= addr1;
                        Mem_wdata <= wdata1;
                        MemRead   <= !we1;
                        MemWrite  <= we1;
                    end
                end
                ACC0: begin
                    ack0 <= 1'b1;
                    // MemRead still carries the sampled direction for this access.
                    if (MemRead) begin
                        rdata0 <= Mem_data;
                    end
                    gnt0     <= 1'b0;
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                end
                ACC1: begin
                    ack1 <= 1'b1;
                    if (MemRead) begin
                        rdata1 <= Mem_data;
                    end
                    if (burst_end) begin
                        last1    <= 1'b1;
                        gnt1     <= 1'b0;
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        beat_q   <= '0;
                    end else begin
                        // Running sum equals start + k*STEP; 32-bit add wraps silently.
                        beat_q    <= beat_q + 1'b1;
                        Mem_addr  <= Mem_addr + STEP;
                        Mem_wdata <= wdata1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int BW   = 4;
    localparam int STEP = 4;

    logic          clk, reset;
    logic          req0, we0, req1, we1;
    logic [31:0]   addr0, wdata0, addr1, wdata1;
    logic [BW-1:0] len1;
    logic          gnt0, gnt1, ack0, ack1, last1, MemRead, MemWrite, busy;
    logic [31:0]   rdata0, rdata1, Mem_addr, Mem_wdata, Mem_data;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: transaction owner, beat index and the expected outputs.
    int          m_owner;   // 0 none, 1 port 0, 2 port 1
    int          m_k, m_len, m_last;
    logic [31:0] m_base;
    logic        m_we;
    logic        e_gnt0, e_gnt1, e_ack0, e_ack1, e_last1, e_rd, e_wr, e_busy;
    logic [31:0] e_rdata0, e_rdata1, e_addr, e_wdata;

    mem_port_arbiter #(.BURST_W(BW), .ADDR_STEP(STEP)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .last1(last1),
        .rdata0(rdata0), .rdata1(rdata1),
        .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .Mem_data(Mem_data), .busy(busy)
    );

    function automatic logic [31:0] memf(logic [31:0] a);
        if (a == 32'h10) return 32'h1234ABCD;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign Mem_data = memf(Mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_k = 0; m_len = 0; m_last = -1; m_base = '0; m_we = 1'b0;
        e_gnt0 = 0; e_gnt1 = 0; e_ack0 = 0; e_ack1 = 0; e_last1 = 0;
        e_rd = 0; e_wr = 0; e_busy = 0;
        e_rdata0 = '0; e_rdata1 = '0; e_addr = '0; e_wdata = '0;
    endtask

    task automatic model_step();
        bit w0, w1;
        if (!reset) begin
            model_reset();
            return;
        end
        e_ack0 = 0; e_ack1 = 0; e_last1 = 0;
        case (m_owner)
            0: begin
                // Tie goes to whichever port was not granted most recently.
                w1 = req1 && (!req0 || m_last == 0);
                w0 = req0 && !w1;
                if (w0) begin
                    m_owner = 1; m_last = 0; m_we = we0;
                    e_gnt0 = 1; e_addr = addr0; e_wdata = wdata0; e_rd = !we0; e_wr = we0;
                end else if (w1) begin
                    m_owner = 2; m_last = 1; m_we = we1; m_k = 0; m_len = int'(len1); m_base = addr1;
                    e_gnt1 = 1; e_addr = addr1; e_wdata = wdata1; e_rd = !we1; e_wr = we1;
                end
            end
            1: begin
                e_ack0 = 1;
                if (!m_we) e_rdata0 = memf(e_addr);
                m_owner = 0; e_gnt0 = 0; e_rd = 0; e_wr = 0;
            end
            default: begin
                e_ack1 = 1;
                if (!m_we) e_rdata1 = memf(e_addr);
                if (m_k == m_len) begin
                    e_last1 = 1; m_owner = 0; e_gnt1 = 0; e_rd = 0; e_wr = 0;
                end else begin
                    m_k++;
                    e_addr  = m_base + 32'(m_k * STEP);
                    e_wdata = wdata1;
                end
            end
        endcase
        e_busy = (m_owner != 0);
    endtask

    task automatic check_all();
        chk("gnt0", 32'(gnt0), 32'(e_gnt0));
        chk("gnt1", 32'(gnt1), 32'(e_gnt1));
        chk("ack0", 32'(ack0), 32'(e_ack0));
        chk("ack1", 32'(ack1), 32'(e_ack1));
        chk("last1", 32'(last1), 32'(e_last1));
        chk("rdata0", rdata0, e_rdata0);
        chk("rdata1", rdata1, e_rdata1);
        chk("mem_addr", Mem_addr, e_addr);
        chk("mem_wdata", Mem_wdata, e_wdata);
        chk("mem_read", 32'(MemRead), 32'(e_rd));
        chk("mem_write", 32'(MemWrite), 32'(e_wr));
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    // Inputs are set before the call; one rising edge, then outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; req1 = 0; we1 = 0; len1 = '0;
    endtask

    logic [31:0] ea;

    initial begin
        reset = 1'b0;
        idle_inputs();
        addr0 = '0; wdata0 = '0; addr1 = '0; wdata1 = '0;
        model_reset();
        @(negedge clk);
        check_all();
        reset = 1'b1;

        // Port-0 read of 0x10.
        req0 = 1; we0 = 0; addr0 = 32'h10; wdata0 = $urandom;
        cycle();
        chk("p0_rd_strobe", 32'(MemRead), 32'd1);
        chk("p0_rd_addr", Mem_addr, 32'h10);
        req0 = 0; addr0 = $urandom;
        cycle();
        chk("p0_rd_ack", 32'(ack0), 32'd1);
        chk("p0_rd_data", rdata0, 32'h1234ABCD);
        chk("p0_rd_busy", 32'(busy), 32'd0);
        cycle();

        // Tie after reset: port 0, idle, port 1, idle, port 0.
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; len1 = 0; addr0 = 32'h40; addr1 = 32'h80;
        cycle();
        chk("tie_first_p0", 32'(gnt0), 32'd1);
        cycle();
        chk("tie_gap", 32'(busy), 32'd0);
        cycle();
        chk("tie_then_p1", 32'(gnt1), 32'd1);
        cycle();
        cycle();
        chk("tie_back_p0", 32'(gnt0), 32'd1);
        idle_inputs();
        cycle(); cycle();

        // Burst write 0x100, four beats; later input changes must not disturb it.
        req1 = 1; we1 = 1; addr1 = 32'h100; len1 = 3;
        for (int i = 0; i < 5; i++) begin
            wdata1 = $urandom;
            cycle();
            req1 = 0; addr1 = $urandom; len1 = 4'($urandom);
            if (i < 4) chk("bw_addr", Mem_addr, 32'h100 + 32'(i * 4));
            if (i >= 1) chk("bw_ack", 32'(ack1), 32'd1);
            if (i >= 1) chk("bw_last", 32'(last1), 32'(i == 4));
        end
        cycle();

        // Burst read across the 32-bit wrap.
        req1 = 1; we1 = 0; addr1 = 32'hFFFF_FFF8; len1 = 2;
        for (int i = 0; i < 4; i++) begin
            wdata1 = $urandom;
            cycle();
            req1 = 0;
            ea = 32'hFFFF_FFF8 + 32'(i * 4);
            if (i < 3) chk("wrap_addr", Mem_addr, ea);
        end
        cycle();

        // Port-0 request raised on beat 0 of a three-beat burst; req1 stays high.
        req1 = 1; we1 = 0; len1 = 2; addr1 = 32'h200;
        cycle();
        req0 = 1; we0 = 1; addr0 = 32'h300; wdata0 = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("wait_gnt0", 32'(gnt0), 32'd0);
        end
        cycle();
        chk("rr_gnt0", 32'(gnt0), 32'd1);
        idle_inputs();
        cycle(); cycle();

        // Reset during beat 2 of an eight-beat burst, both ports pending afterwards.
        req1 = 1; we1 = 1; len1 = 7; addr1 = 32'h400;
        cycle();
        req1 = 0;
        cycle(); cycle();
        req0 = 1; req1 = 1; we0 = 0; addr0 = 32'h10;
        do_reset();
        cycle();
        chk("post_rst_gnt0", 32'(gnt0), 32'd1);
        chk("post_rst_ack1", 32'(ack1), 32'd0);
        idle_inputs();
        cycle(); cycle();

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 4000; n++) begin
            req0   = ($urandom_range(0, 2) == 0);
            req1   = ($urandom_range(0, 2) == 0);
            we0    = $urandom_range(0, 1) == 1;
            we1    = $urandom_range(0, 1) == 1;
            addr0  = $urandom;
            wdata0 = $urandom;
            wdata1 = $urandom;
            addr1  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : $urandom;
            len1   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter BURST_W, default 4, meaning width of the port-1 burst length field (max beats 2^BURST_W).
REQ-002 The block SHALL have parameter ADDR_STEP, default 4, meaning the byte increment between port-1 burst beats.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  port-0 (CPU) single-access request.
- we0  in  1  port-0 write enable (1 write, 0 read).
- addr0  in  32  port-0 byte address.
- wdata0  in  32  port-0 write data.
- req1  in  1  port-1 (loader/DMA) burst request.
- we1  in  1  port-1 write enable.
- addr1  in  32  port-1 burst start address.
- wdata1  in  32  port-1 write data for the current beat.
- len1  in  BURST_W  port-1 beat count minus one.
- gnt0, gnt1  out  1  grant flags; high during the owning port's access cycles.
- ack0, ack1  out  1  one-cycle pulse per completed beat.
- last1  out  1  high with ack1 on the final burst beat.
- rdata0, rdata1  out  32  registered read data, valid while the matching ack is high.
- Mem_addr  out  32  shared memory address.
- Mem_wdata  out  32  shared memory write data.
- MemRead, MemWrite  out  1  shared memory strobes.
- Mem_data  in  32  combinational read data returned by the memory.
- busy  out  1  high when the state is not IDLE.

Function
REQ-004 States SHALL be IDLE, ACC0 and ACC1; every transaction SHALL return to IDLE for at least one cycle before the next grant.
REQ-005 In IDLE, with only reqX high, the next edge SHALL enter ACCX.
REQ-006 In IDLE, with both requests high, the port not granted most recently SHALL win; after reset, port 0 SHALL win.
REQ-007 On entering ACCX, the block SHALL register the grant, Mem_addr, Mem_wdata and MemRead=!weX or MemWrite=weX; the strobes SHALL be mutually exclusive.
REQ-008 ACC0 SHALL last exactly one cycle, with addr0, wdata0 and we0 sampled at the IDLE->ACC0 edge.
REQ-009 At the edge ending ACC0, the block SHALL set ack0=1 for one cycle, load rdata0 from Mem_data on a read (hold the old value on a write), and go to IDLE.
REQ-010 ACC1 SHALL last len1+1 consecutive cycles, with len1, we1 and addr1 sampled at entry.
REQ-011 The beat counter SHALL start at 0; beat k SHALL drive Mem_addr = addr1 + k*ADDR_STEP, modulo 2^32 (wraps silently), with Mem_wdata = wdata1 as sampled at the edge starting beat k.
REQ-012 Each ACC1 beat end SHALL pulse ack1 and load rdata1 on reads.
REQ-013 last1 SHALL accompany ack1 when k = len1, and ACC1 SHALL then go to IDLE.
REQ-014 Read-to-ack latency SHALL be 2 cycles from a request seen in IDLE; burst acks SHALL arrive on consecutive cycles.
REQ-015 Deasserting reqX during ACCX SHALL NOT abort the access or burst; reqX still high in IDLE after its ack SHALL be treated as a new request.
REQ-016 In IDLE, gnt0, gnt1, MemRead and MemWrite SHALL be 0; Mem_addr and Mem_wdata SHALL hold their last values.
REQ-017 len1 = 0 SHALL produce a single-beat burst with last1=1 on its only ack.
REQ-018 A port-0 request arriving during ACC1 SHALL wait; round-robin SHALL then grant port 0 at the next IDLE even if req1 is high.

Reset
REQ-019 reset=0 SHALL immediately, without waiting for a clock edge, force state IDLE, priority to port 0, beat counter 0 and all outputs to 0, including rdata0, rdata1, Mem_addr and Mem_wdata.
REQ-020 Reset asserted mid-burst SHALL drop MemWrite within the same cycle; remaining beats SHALL be discarded and no ack SHALL follow.
REQ-021 After reset release, the first edge with reset=1 SHALL evaluate requests from IDLE.

Verification
REQ-022 Port-0 read: req0=1, we0=0, addr0=0x10, memory word 0x1234ABCD -> MemRead=1 and Mem_addr=0x10 at cycle 1; ack0=1 and rdata0=0x1234ABCD at cycle 2; busy=0 at cycle 2.
REQ-023 Simultaneous request after reset: req0=req1=1 -> port 0 granted first; port 1 granted after one IDLE cycle; next tie goes to port 0.
REQ-024 Burst write: req1=1, we1=1, addr1=0x100, len1=3 -> Mem_addr 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles, 4 ack1 pulses, last1 only on the 4th.
REQ-025 Address wrap: addr1=0xFFFFFFF8, len1=2 -> Mem_addr 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-026 Reset mid-burst: reset=0 on beat 2 of len1=7 -> MemWrite, gnt1 and busy are 0 immediately; no further ack1; after release, a pending req0 is granted first.
REQ-027 Port-0 request during burst: req0 raised on beat 0 of len1=2 -> gnt0 stays 0 until the burst and one IDLE cycle finish, then port 0 completes its single access.
